// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read, retired-write and trap-capture update paths.
// Define CSR_PERF_COUNTER_EN to build the 64-bit mcycle/minstret counters.

module csr_file #(
   parameter int unsigned CSR_ADDR_WIDTH = 12,
   parameter int unsigned REG_DATA_WIDTH = 32,
   parameter logic [REG_DATA_WIDTH-1:0] MHARTID_VALUE = '0,
   parameter logic [REG_DATA_WIDTH-1:0] MISA_VALUE = 32'h40001100
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CSR_ADDR_WIDTH-1:0] excsr_csrf_addr,
   output logic [REG_DATA_WIDTH-1:0] csrf_excsr_data,
   input  logic                      commit_csr_we,
   input  logic [CSR_ADDR_WIDTH-1:0] commit_csr_addr,
   input  logic [REG_DATA_WIDTH-1:0] commit_csr_data,
   input  logic                      commit_trap_en,
   input  logic [REG_DATA_WIDTH-1:0] commit_trap_pc,
   input  logic [REG_DATA_WIDTH-1:0] commit_trap_cause,
   input  logic [REG_DATA_WIDTH-1:0] commit_trap_value,
   input  logic [1:0]                commit_retire_num,
   output logic [REG_DATA_WIDTH-1:0] mtvec_out,
   output logic [REG_DATA_WIDTH-1:0] mepc_out
);

   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS  = CSR_ADDR_WIDTH'(12'h300);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MISA     = CSR_ADDR_WIDTH'(12'h301);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MIE      = CSR_ADDR_WIDTH'(12'h304);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVEC    = CSR_ADDR_WIDTH'(12'h305);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSCRATCH = CSR_ADDR_WIDTH'(12'h340);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC     = CSR_ADDR_WIDTH'(12'h341);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE   = CSR_ADDR_WIDTH'(12'h342);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVAL    = CSR_ADDR_WIDTH'(12'h343);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MIP      = CSR_ADDR_WIDTH'(12'h344);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MHARTID  = CSR_ADDR_WIDTH'(12'hF14);
   localparam logic [REG_DATA_WIDTH-1:0] ALIGN_MASK    = ~REG_DATA_WIDTH'(3);

   logic [REG_DATA_WIDTH-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q;
   logic [REG_DATA_WIDTH-1:0] mepc_q, mcause_q, mtval_q, mip_q;
   logic                      wr_en;

   // A trap in the same cycle swallows the retired CSR write.
   assign wr_en = commit_csr_we & ~commit_trap_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mstatus_q  <= '0;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mip_q      <= '0;
      end else begin
         if (wr_en) begin
            case (commit_csr_addr)
               ADDR_MSTATUS:  mstatus_q  <= commit_csr_data;
               ADDR_MIE:      mie_q      <= commit_csr_data;
               ADDR_MTVEC:    mtvec_q    <= commit_csr_data & ALIGN_MASK;
               ADDR_MSCRATCH: mscratch_q <= commit_csr_data;
               ADDR_MEPC:     mepc_q     <= commit_csr_data & ALIGN_MASK;
               ADDR_MCAUSE:   mcause_q   <= commit_csr_data;
               ADDR_MTVAL:    mtval_q    <= commit_csr_data;
               ADDR_MIP:      mip_q      <= commit_csr_data;
               default: ;
            endcase
         end
         if (commit_trap_en) begin
            mepc_q   <= commit_trap_pc & ALIGN_MASK;
            mcause_q <= commit_trap_cause;
            mtval_q  <= commit_trap_value;
         end
      end
   end

`ifdef CSR_PERF_COUNTER_EN
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCYCLE    = CSR_ADDR_WIDTH'(12'hB00);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MINSTRET  = CSR_ADDR_WIDTH'(12'hB02);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCYCLEH   = CSR_ADDR_WIDTH'(12'hB80);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MINSTRETH = CSR_ADDR_WIDTH'(12'hB82);
   localparam int unsigned CW = 2 * REG_DATA_WIDTH;

   logic [CW-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

   // A written half takes the commit data; the other half holds rather than increments.
   always_comb begin
      mcycle_d   = mcycle_q + CW'(1);
      minstret_d = minstret_q + CW'(commit_retire_num);
      if (wr_en) begin
         case (commit_csr_addr)
            ADDR_MCYCLE:    mcycle_d   = {mcycle_q[CW-1:REG_DATA_WIDTH], commit_csr_data};
            ADDR_MCYCLEH:   mcycle_d   = {commit_csr_data, mcycle_q[REG_DATA_WIDTH-1:0]};
            ADDR_MINSTRET:  minstret_d = {minstret_q[CW-1:REG_DATA_WIDTH], commit_csr_data};
            ADDR_MINSTRETH: minstret_d = {commit_csr_data, minstret_q[REG_DATA_WIDTH-1:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`else
   logic [1:0] unused_retire_num;
   assign unused_retire_num = commit_retire_num;
`endif

   always_comb begin
      csrf_excsr_data = '0;
      case (excsr_csrf_addr)
         ADDR_MSTATUS:   csrf_excsr_data = mstatus_q;
         ADDR_MISA:      csrf_excsr_data = MISA_VALUE;
         ADDR_MIE:       csrf_excsr_data = mie_q;
         ADDR_MTVEC:     csrf_excsr_data = mtvec_q;
         ADDR_MSCRATCH:  csrf_excsr_data = mscratch_q;
         ADDR_MEPC:      csrf_excsr_data = mepc_q;
         ADDR_MCAUSE:    csrf_excsr_data = mcause_q;
         ADDR_MTVAL:     csrf_excsr_data = mtval_q;
         ADDR_MIP:       csrf_excsr_data = mip_q;
         ADDR_MHARTID:   csrf_excsr_data = MHARTID_VALUE;
`ifdef CSR_PERF_COUNTER_EN
         ADDR_MCYCLE:    csrf_excsr_data = mcycle_q[REG_DATA_WIDTH-1:0];
         ADDR_MCYCLEH:   csrf_excsr_data = mcycle_q[CW-1:REG_DATA_WIDTH];
         ADDR_MINSTRET:  csrf_excsr_data = minstret_q[REG_DATA_WIDTH-1:0];
         ADDR_MINSTRETH: csrf_excsr_data = minstret_q[CW-1:REG_DATA_WIDTH];
`endif
         default: ;
      endcase
   end

   assign mtvec_out = mtvec_q;
   assign mepc_out  = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: expected read values are queued when stimulus is
// driven and popped when the combinational read is sampled mid-cycle.

module tb_csr_file;

   logic        clk;
   logic        rst;
   logic [11:0] rd_addr;
   logic [31:0] rd_data;
   logic        we;
   logic [11:0] waddr;
   logic [31:0] wdata;
   logic        trap_en;
   logic [31:0] trap_pc, trap_cause, trap_value;
   logic [1:0]  retire_num;
   logic [31:0] mtvec_o, mepc_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [11:0] addr;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   csr_file dut (
      .clk               (clk),
      .rst               (rst),
      .excsr_csrf_addr   (rd_addr),
      .csrf_excsr_data   (rd_data),
      .commit_csr_we     (we),
      .commit_csr_addr   (waddr),
      .commit_csr_data   (wdata),
      .commit_trap_en    (trap_en),
      .commit_trap_pc    (trap_pc),
      .commit_trap_cause (trap_cause),
      .commit_trap_value (trap_value),
      .commit_retire_num (retire_num),
      .mtvec_out         (mtvec_o),
      .mepc_out          (mepc_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      exp_t e;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sb.push_back('{"reset_mstatus", 12'h300, 32'h0});
      sb.push_back('{"reset_mhartid", 12'hF14, 32'h0});
      sb.push_back('{"reset_misa", 12'h301, 32'h40001100});
      sb.push_back('{"reset_mscratch", 12'h340, 32'h0});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
         end
      end
      checks++;
      if (mtvec_o !== 32'h0 || mepc_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_outs: got mtvec %h mepc %h expected 0 0", mtvec_o, mepc_o);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_no_bypass();
      exp_t e;
      @(posedge clk); #1;
      we = 1'b1; waddr = 12'h340; wdata = 32'hDEADBEEF; rd_addr = 12'h340;
      sb.push_back('{"mscratch_old_same_cycle", 12'h340, 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
      end
      @(posedge clk); #1;
      we = 1'b0;
      sb.push_back('{"mscratch_new_next_cycle", 12'h340, 32'hDEADBEEF});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
      end
   endtask

   task automatic test_trap_priority();
      exp_t e;
      @(posedge clk); #1;
      trap_en = 1'b1; trap_pc = 32'h80000103; trap_cause = 32'h2; trap_value = 32'h13;
      we = 1'b1; waddr = 12'h341; wdata = 32'h55;
      sb.push_back('{"trap_mepc", 12'h341, 32'h80000100});
      sb.push_back('{"trap_mcause", 12'h342, 32'h2});
      sb.push_back('{"trap_mtval", 12'h343, 32'h13});
      @(posedge clk); #1;
      trap_en = 1'b0; we = 1'b0;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
         end
      end
      checks++;
      if (mepc_o !== 32'h80000100) begin
         errors++;
         $display("FAIL trap_mepc_out: got %h expected %h", mepc_o, 32'h80000100);
      end
   endtask

   task automatic test_align();
      @(posedge clk); #1;
      we = 1'b1; waddr = 12'h305; wdata = 32'h80000007;
      @(negedge clk);
      checks++;
      if (mtvec_o !== 32'h0) begin
         errors++;
         $display("FAIL mtvec_out_before_edge: got %h expected %h", mtvec_o, 32'h0);
      end
      @(posedge clk); #1;
      waddr = 12'h341; wdata = 32'h12345677;
      @(negedge clk);
      checks++;
      if (mtvec_o !== 32'h80000004) begin
         errors++;
         $display("FAIL mtvec_out_aligned: got %h expected %h", mtvec_o, 32'h80000004);
      end
      @(posedge clk); #1;
      we = 1'b0;
      @(negedge clk);
      checks++;
      if (mepc_o !== 32'h12345674) begin
         errors++;
         $display("FAIL mepc_out_aligned: got %h expected %h", mepc_o, 32'h12345674);
      end
   endtask

   task automatic test_rw_regs();
      logic [11:0] addrs [8];
      logic [11:0] ro_addrs [3];
      logic [31:0] ro_exp [3];
      logic [31:0] d;
      exp_t e;
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};
      ro_addrs = '{12'h301, 12'hF14, 12'h7C0};
      ro_exp = '{32'h40001100, 32'h0, 32'h0};
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         d = $urandom;
         we = 1'b1; waddr = addrs[i]; wdata = d;
         if (addrs[i] == 12'h305 || addrs[i] == 12'h341) d = d & 32'hFFFFFFFC;
         sb.push_back('{$sformatf("rw_%h", addrs[i]), addrs[i], d});
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         we = 1'b1; waddr = ro_addrs[i]; wdata = 32'hFFFFFFFF;
         sb.push_back('{$sformatf("ro_%h", ro_addrs[i]), ro_addrs[i], ro_exp[i]});
      end
      @(posedge clk); #1;
      we = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
         end
      end
   endtask

   task automatic test_counters();
      exp_t e;
`ifdef CSR_PERF_COUNTER_EN
      @(posedge clk); #1;
      we = 1'b1; waddr = 12'hB02; wdata = 32'hFFFFFFFE; retire_num = 2'd0;
      @(posedge clk); #1;
      waddr = 12'hB82; wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      we = 1'b0; retire_num = 2'd3;
      @(posedge clk); #1;
      retire_num = 2'd0;
      sb.push_back('{"minstret_wrap_lo", 12'hB02, 32'h1});
      sb.push_back('{"minstret_wrap_hi", 12'hB82, 32'h0});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
         end
      end
      @(posedge clk); #1;
      we = 1'b1; waddr = 12'hB00; wdata = 32'h10;
      @(posedge clk); #1;
      we = 1'b0;
      sb.push_back('{"mcycle_written", 12'hB00, 32'h10});
      sb.push_back('{"mcycle_hi_held", 12'hB80, 32'h0});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
         end
      end
      sb.push_back('{"mcycle_incremented", 12'hB00, 32'h11});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      rd_addr = e.addr;
      #1;
      checks++;
      if (rd_data !== e.exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
      end
`else
      @(posedge clk); #1;
      we = 1'b1; waddr = 12'hB00; wdata = 32'h1234; retire_num = 2'd3;
      @(posedge clk); #1;
      we = 1'b0; retire_num = 2'd0;
      sb.push_back('{"no_mcycle", 12'hB00, 32'h0});
      sb.push_back('{"no_minstret", 12'hB02, 32'h0});
      sb.push_back('{"no_mcycleh", 12'hB80, 32'h0});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
         end
      end
`endif
   endtask

   task automatic test_reset_mid_write();
      exp_t e;
      @(posedge clk); #1;
      we = 1'b1; waddr = 12'h300; wdata = 32'hA5A5A5A5;
      #2;
      rst = 1'b0;
      sb.push_back('{"async_clr_mscratch", 12'h340, 32'h0});
      sb.push_back('{"async_clr_mie", 12'h304, 32'h0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
         end
      end
      checks++;
      if (mtvec_o !== 32'h0 || mepc_o !== 32'h0) begin
         errors++;
         $display("FAIL async_clr_outs: got mtvec %h mepc %h expected 0 0", mtvec_o, mepc_o);
      end
      @(posedge clk);
      sb.push_back('{"held_no_write", 12'h300, 32'h0});
      sb.push_back('{"held_mtval", 12'h343, 32'h0});
`ifdef CSR_PERF_COUNTER_EN
      sb.push_back('{"held_mcycle", 12'hB00, 32'h0});
`endif
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_addr = e.addr;
         #1;
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
         end
      end
      @(posedge clk); #1;
      rst = 1'b1;
      rd_addr = 12'h300;
      sb.push_back('{"released_before_edge", 12'h300, 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
      end
      @(posedge clk); #1;
      we = 1'b0;
      sb.push_back('{"write_resumes", 12'h300, 32'hA5A5A5A5});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
      end
   endtask

   initial begin
      rst = 1'b0; rd_addr = '0; we = 1'b0; waddr = '0; wdata = '0;
      trap_en = 1'b0; trap_pc = '0; trap_cause = '0; trap_value = '0; retire_num = 2'd0;
      test_reset();
      test_no_bypass();
      test_trap_priority();
      test_align();
      test_rw_regs();
      test_counters();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter MHARTID_VALUE, default 0, the constant returned for mhartid (0xF14).
REQ-002 SHALL have parameter MISA_VALUE, default 32'h40001100, the constant returned for misa (0x301), which is RV32IM.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port excsr_csrf_addr, input, CSR_ADDR_WIDTH bits, the read address from the execute CSR unit.
REQ-006 SHALL have port csrf_excsr_data, output, REG_DATA_WIDTH bits, the read data returned to the execute CSR unit.
REQ-007 SHALL have ports commit_csr_we (input, 1), commit_csr_addr (input, CSR_ADDR_WIDTH) and commit_csr_data (input, REG_DATA_WIDTH), forming the retired CSR write.
REQ-008 SHALL have ports commit_trap_en (input, 1), commit_trap_pc (input, REG_DATA_WIDTH), commit_trap_cause (input, REG_DATA_WIDTH) and commit_trap_value (input, REG_DATA_WIDTH), forming the trap record.
REQ-009 SHALL have port commit_retire_num, input, 2 bits, the number of instructions retired this cycle (0..3).
REQ-010 SHALL have ports mtvec_out and mepc_out, outputs, REG_DATA_WIDTH each, giving registered values to fetch/commit.

Function
REQ-011 SHALL implement storage for mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343 and mip 0x344, each REG_DATA_WIDTH wide.
REQ-012 SHALL provide a combinational read: csrf_excsr_data = selected CSR value in the same cycle as excsr_csrf_addr.
REQ-013 SHALL return 0 on a read of an unimplemented address; misa and mhartid SHALL read as their parameter values.
REQ-014 SHALL perform no read bypass: a read in the same cycle as a write to that CSR returns the old value, and the new value is visible the next cycle.
REQ-015 SHALL update the addressed register at the clk edge when commit_csr_we=1; writes to read-only or unimplemented addresses SHALL be ignored.
REQ-016 SHALL write on commit_trap_en=1, at the same edge: mepc<=commit_trap_pc, mcause<=commit_trap_cause, mtval<=commit_trap_value.
REQ-017 SHALL give the trap priority: if commit_trap_en and commit_csr_we are both 1 in one cycle, the CSR write is dropped entirely.
REQ-018 SHALL force mepc bits [1:0] and mtvec bits [1:0] to 0 on every write path.
REQ-019 SHALL drive mtvec_out and mepc_out directly from the registers, so an update shows one cycle after the write.

Reset
REQ-020 SHALL, on rst=0, asynchronously clear every writable CSR and counter to 0; csrf_excsr_data then reflects 0 for those addresses.
REQ-021 SHALL treat reset asserted mid-write as dominant: no write lands while rst=0.
REQ-022 SHALL resume updates on the first clk edge after rst deasserts.

Configuration
REQ-023 SHALL use the macro CSR_PERF_COUNTER_EN to compile the performance counters in or out.
REQ-024 SHALL, with CSR_PERF_COUNTER_EN defined, implement 64-bit mcycle (0xB00 low, 0xB80 high) and minstret (0xB02 low, 0xB82 high).
REQ-025 SHALL increment mcycle by 1 every cycle and minstret by commit_retire_num, wrapping from all-ones to 0.
REQ-026 SHALL let a commit write to a counter half win over that cycle's increment, with the other half unchanged.
REQ-027 SHALL, without CSR_PERF_COUNTER_EN, omit these counters; their addresses read 0 and ignore writes.

Verification
REQ-028 SHALL cover: reset, then read 0x300 and 0xF14 -> both return 0; read 0x301 -> returns 0x40001100.
REQ-029 SHALL cover: commit write 0x340=0xDEADBEEF while reading 0x340 -> returns the old value 0 that cycle and 0xDEADBEEF the next.
REQ-030 SHALL cover: trap (pc=0x80000103, cause=2, value=0x13) together with a CSR write to 0x341=0x55 -> mepc=0x80000100, mcause=2, mtval=0x13, and the 0x55 write is lost.
REQ-031 SHALL cover: commit write 0x305=0x80000007 -> mtvec_out=0x80000004 one cycle later.
REQ-032 SHALL cover, with CSR_PERF_COUNTER_EN: minstret=0xFFFFFFFF_FFFFFFFE and retire_num=3 -> minstret=0x1; mcycle low written 0x10 -> reads 0x10 next cycle, then 0x11.
REQ-033 SHALL cover: rst pulled low mid-stream with commit_csr_we=1 -> all CSRs read 0 with no write applied.
